// File: rtl/output_port_tx.sv
// Output port of the basic computer: latches AC[7:0] into OUTR on OUT and
// shifts it out as an 8N1 frame, holding FGO low until the stop bit ends.
module output_port_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] in_data,
   output logic [7:0]  out_data,
   output logic        fgo,
   output logic        tx,
   output logic        overrun
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_param
      $error("output_port_tx: CLKS_PER_BIT out of range");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      idx, idx_nxt;
   logic [7:0]      out_nxt;
   logic            tx_nxt, fgo_nxt, ovr_nxt;
   logic            bit_end;

   // Only the low byte of the accumulator bus reaches the port.
   logic unused_hi;
   assign unused_hi = ^in_data[15:8];

   assign bit_end = (cnt == LAST);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      out_nxt   = out_data;
      ovr_nxt   = load & ~fgo;
      case (state)
         IDLE: begin
            if (load) begin
               out_nxt   = in_data[7:0];
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_nxt   = '0;
               state_nxt = DATA;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_nxt = '0;
               idx_nxt = idx + 3'd1;
               if (idx == 3'd7) state_nxt = STOP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // tx/fgo are registered from the next state so the line and flag
      // change on the same edge as the state itself.
      fgo_nxt = (state_nxt == IDLE);
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = out_nxt[idx_nxt];
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         out_data <= 8'h00;
         fgo      <= 1'b1;
         tx       <= 1'b1;
         overrun  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         idx      <= idx_nxt;
         out_data <= out_nxt;
         fgo      <= fgo_nxt;
         tx       <= tx_nxt;
         overrun  <= ovr_nxt;
      end
   end

endmodule

// File: tb/tb_output_port_tx.sv
// Bench for output_port_tx: frame-position model checked every cycle, plus
// directed frames with hand-computed bit patterns.
module tb_output_port_tx;
   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] in_data = 16'h0;
   logic [7:0]  out_data;
   logic        fgo, tx, overrun;

   int checks = 0;
   int failures = 0;

   output_port_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .in_data(in_data),
      .out_data(out_data), .fgo(fgo), .tx(tx), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: a frame is just a position 0..FRAME-1 since the accepted load.
   logic       m_fgo = 1'b1;
   logic       m_ovr = 1'b0;
   logic [7:0] m_out = 8'h00;
   int         m_pos = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_fgo = 1'b1; m_ovr = 1'b0; m_out = 8'h00; m_pos = 0;
      end else begin
         m_ovr = load && !m_fgo;
         if (m_fgo && load) begin
            m_out = in_data[7:0]; m_pos = 0; m_fgo = 1'b0;
         end else if (!m_fgo) begin
            m_pos++;
            if (m_pos == FRAME) m_fgo = 1'b1;
         end
      end
   end

   function automatic logic m_tx();
      int b;
      if (m_fgo) return 1'b1;
      b = m_pos / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_out[b-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      check("model_tx", tx, m_tx());
      check("model_fgo", fgo, m_fgo);
      check("model_out_data", out_data, m_out);
      check("model_overrun", overrun, m_ovr);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Loads d, then observes the 40 frame cycles; optionally injects a
   // busy load of 00FF at cycle inj.
   task automatic frame(input logic [15:0] d, input int inj, output logic [9:0] bits,
                        output int fgo_low, output int ovr_cnt, output int out_bad,
                        output int tx_low, output int first_high);
      bits = '0; fgo_low = 0; ovr_cnt = 0; out_bad = 0; tx_low = 0; first_high = -1;
      load = 1'b1; in_data = d;
      tick();
      load = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
         if (c == inj) begin load = 1'b1; in_data = 16'h00FF; end
         if (c == inj + 1) load = 1'b0;
         if (c % CPB == CPB / 2) bits[c / CPB] = tx;
         if (!fgo) fgo_low++;
         if (overrun) ovr_cnt++;
         if (out_data !== d[7:0]) out_bad++;
         if (!tx) tx_low++;
         else if (first_high < 0) first_high = c;
         tick();
      end
   endtask

   logic [9:0] bits;
   int fgo_low, ovr_cnt, out_bad, tx_low, first_high;
   int falls[$];
   int ovr_between;
   logic prev_fgo;

   initial begin
      tick(); tick();
      check("reset_tx", tx, 1'b1);
      check("reset_fgo", fgo, 1'b1);
      check("reset_out_data", out_data, 8'h00);
      check("reset_overrun", overrun, 1'b0);
      rst_n = 1'b1;
      tick();

      // Single byte A5: frame 0,1,0,1,0,0,1,0,1,1
      frame(16'h12A5, -1, bits, fgo_low, ovr_cnt, out_bad, tx_low, first_high);
      check("a5_bits", bits, 10'b1101001010);
      check("a5_fgo_low", fgo_low, FRAME);
      check("a5_out_data", out_bad, 0);
      check("a5_fgo_back", fgo, 1'b1);
      tick();

      // Overrun: busy load of FF must not disturb the 33 frame
      frame(16'h0033, 10, bits, fgo_low, ovr_cnt, out_bad, tx_low, first_high);
      check("ovr_bits", bits, 10'b1001100110);
      check("ovr_pulses", ovr_cnt, 1);
      check("ovr_out_data", out_bad, 0);
      tick();

      // Byte 80: 32 low cycles then high from cycle 32
      frame(16'h0080, -1, bits, fgo_low, ovr_cnt, out_bad, tx_low, first_high);
      check("b80_bits", bits, 10'b1100000000);
      check("b80_tx_low", tx_low, 32);
      check("b80_first_high", first_high, 32);
      tick();

      // Back-to-back with load held high
      load = 1'b1; in_data = 16'h0000;
      prev_fgo = fgo; ovr_between = 0;
      for (int c = 0; c < 130; c++) begin
         tick();
         if (prev_fgo && !fgo) falls.push_back(c);
         if (falls.size() == 1 && overrun) ovr_between++;
         prev_fgo = fgo;
      end
      load = 1'b0;
      check("b2b_frames", falls.size(), 4);
      if (falls.size() >= 3) begin
         check("b2b_period1", falls[1] - falls[0], FRAME + 1);
         check("b2b_period2", falls[2] - falls[1], FRAME + 1);
      end
      check("b2b_overrun_cycles", ovr_between, FRAME);
      repeat (FRAME + 5) tick();

      // Reset mid-frame of 5A, then a clean C3 frame
      load = 1'b1; in_data = 16'h005A;
      tick();
      load = 1'b0;
      repeat (17) tick();
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_tx", tx, 1'b1);
      check("midrst_fgo", fgo, 1'b1);
      check("midrst_out_data", out_data, 8'h00);
      check("midrst_overrun", overrun, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      frame(16'h00C3, -1, bits, fgo_low, ovr_cnt, out_bad, tx_low, first_high);
      check("c3_bits", bits, 10'b1110000110);
      check("c3_fgo_low", fgo_low, FRAME);
      check("c3_out_data", out_bad, 0);
      tick();

      // Random loads and occasional reset pulses against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 599) == 0) begin
            load = 1'b0; rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end else begin
            load = ($urandom_range(0, 5) == 0);
            in_data = 16'($urandom);
         end
         tick();
      end
      load = 1'b0;
      repeat (FRAME + 5) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
